givens_bram_arbiter: RTL and testbench
======================================

GIVENS_BRAM_ARBITER -- requirements
Module: givens_bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, Givens BRAM row address width (4 rows).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM row width (4 x 8-bit elements).
REQ-003 SHALL have parameter WDOG_CYCLES, default 16, watchdog grant limit in cycles (used only under REQ-030).
REQ-004 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_wr  in  1  Givens-rotation writer requests port; held for whole burst.
- wr_addr  in  ADDR_WIDTH  writer row address.
- wr_data  in  DATA_WIDTH  writer row data.
- wr_last  in  1  marks writer's final beat.
- req_rd  in  1  flattener/reader requests port; held for whole burst.
- rd_addr  in  ADDR_WIDTH  reader row address.
- rd_last  in  1  marks reader's final beat.
- gnt_wr  out  1  writer owns BRAM port.
- gnt_rd  out  1  reader owns BRAM port.
- rd_data  out  DATA_WIDTH  registered read data to reader.
- rd_valid  out  1  rd_data valid this cycle.
- ena  out  1  BRAM enable.
- wea  out  1  BRAM write enable.
- addra  out  ADDR_WIDTH  BRAM address.
- dina  out  DATA_WIDTH  BRAM write data.
- douta  in  DATA_WIDTH  BRAM read data (1-cycle latency).
- timeout_err  out  1  one-cycle pulse on watchdog revocation.

Function
REQ-005 SHALL implement FSM states IDLE, OWN_WR, OWN_RD; gnt_wr = (state==OWN_WR), gnt_rd = (state==OWN_RD), registered.
REQ-006 In IDLE, one requester active: that requester SHALL be granted the next cycle.
REQ-007 In IDLE, both active: SHALL grant requester not served last (round-robin pointer); after reset pointer favours writer.
REQ-008 Pointer SHALL update to the granted requester on every grant.
REQ-009 A beat SHALL be any cycle with gnt_x=1 and req_x=1; ena=1 during beats only, else 0.
REQ-010 During writer beat: wea=1, addra=wr_addr, dina=wr_data; during reader beat: wea=0, addra=rd_addr, dina=0; outside beats addra=0, dina=0, wea=0.
REQ-011 Beat with last=1 SHALL return FSM to IDLE next cycle; IDLE lasts at least one cycle between grants.
REQ-012 req_x dropping while granted without last SHALL abort: no beat that cycle, IDLE next cycle.
REQ-013 rd_valid SHALL assert exactly one cycle after each reader beat, rd_data = douta sampled that cycle; otherwise rd_valid=0, rd_data holds.
REQ-014 rd_valid of a final reader beat SHALL still be issued even though FSM is in IDLE or OWN_WR.
REQ-015 Requests from the non-granted requester SHALL be ignored (no beat, no side effect) until it wins arbitration.
REQ-016 last asserted with req low SHALL be ignored.
REQ-017 Grant SHALL never be given to both requesters in the same cycle.

Reset
REQ-018 rst=1 SHALL immediately force IDLE, pointer to writer, and all outputs to 0 (gnt_wr, gnt_rd, rd_data, rd_valid, ena, wea, addra, dina, timeout_err).
REQ-019 Reset mid-burst SHALL drop any pending rd_valid; no BRAM access after rst rises.
REQ-020 After rst deasserts, arbitration SHALL resume at the first rising edge.

Configuration
REQ-030 With macro GIVENS_ARB_WATCHDOG_EN defined: counter SHALL count cycles in OWN_WR/OWN_RD; on reaching WDOG_CYCLES without a last beat, grant revoked (IDLE next cycle), timeout_err pulses 1 cycle, pointer set to the other requester; counter cleared on entering IDLE.
REQ-031 Without GIVENS_ARB_WATCHDOG_EN: no counter, grant held until last or abort, timeout_err tied 0.

Verification
REQ-040 After reset, req_wr held, wr_addr 0..3, wr_data 0x11111111/22222222/33333333/44444444, wr_last on 4th -> gnt_wr one cycle after req, ena=wea=1 four cycles, gnt_wr low the cycle after last.
REQ-041 Then req_rd, rd_addr 0..3, rd_last on 4th -> four rd_valid pulses, each one cycle after its beat, rd_data 0x11111111..0x44444444 in order.
REQ-042 req_wr and req_rd rise together after reset -> writer granted first; reader granted after writer's last plus one IDLE cycle; repeat simultaneous -> writer again, since reader was served last.
REQ-043 rst pulsed during 2nd beat of read burst -> all outputs 0 same cycle, no rd_valid for that beat, IDLE after release.
REQ-044 req_rd dropped after 2 beats without rd_last -> gnt_rd low next cycle, 2 rd_valid pulses only; pending req_wr granted after IDLE.
REQ-045 GIVENS_ARB_WATCHDOG_EN defined, req_rd held 20 cycles without rd_last, req_wr pending -> gnt_rd revoked after 16 cycles, timeout_err one pulse, writer granted next; undefined -> gnt_rd held all 20 cycles, timeout_err 0.

Source files
------------

// File: rtl/givens_bram_arbiter_if.sv
// Bundle of the writer, reader and BRAM-port signals around givens_bram_arbiter.
// The arbiter connects through the slave modport; requesters and the BRAM sit on the master side.
interface givens_bram_arbiter_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
);
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  req_rd;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_last;
  logic                  gnt_wr;
  logic                  gnt_rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  ena;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  timeout_err;

  modport master (
    output req_wr, wr_addr, wr_data, wr_last,
    output req_rd, rd_addr, rd_last,
    output douta,
    input  gnt_wr, gnt_rd, rd_data, rd_valid,
    input  ena, wea, addra, dina, timeout_err
  );

  modport slave (
    input  req_wr, wr_addr, wr_data, wr_last,
    input  req_rd, rd_addr, rd_last,
    input  douta,
    output gnt_wr, gnt_rd, rd_data, rd_valid,
    output ena, wea, addra, dina, timeout_err
  );
endinterface

// File: rtl/givens_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port between the Givens writer and the reader.
// Optional grant watchdog is built when GIVENS_ARB_WATCHDOG_EN is defined.
//
// state  | meaning
// IDLE   | no owner; arbitrate between pending requests
// OWN_WR | writer owns the BRAM port until its last beat, abort or watchdog
// OWN_RD | reader owns the BRAM port until its last beat, abort or watchdog
module givens_bram_arbiter #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int WDOG_CYCLES = 16
) (
  input logic                clk,
  input logic                rst,
  givens_bram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_WR = 2'd1,
    OWN_RD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  favour_rd_q, favour_rd_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic                  wr_beat;
  logic                  rd_beat;
  logic                  wdog_trip;

  if (WDOG_CYCLES < 1) begin : g_wdog_param_check
    $error("WDOG_CYCLES must be at least 1");
  end

  assign wr_beat = (state_q == OWN_WR) && bus.req_wr;
  assign rd_beat = (state_q == OWN_RD) && bus.req_rd;

`ifdef GIVENS_ARB_WATCHDOG_EN
  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  // Down-counter reloaded in IDLE; reaching zero on a non-final beat ends the grant.
  assign wdog_trip = ((wr_beat && !bus.wr_last) || (rd_beat && !bus.rd_last))
                     && (wdog_q == '0);

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = wdog_trip;
    if (state_q == IDLE) begin
      wdog_d = CNT_LOAD;
    end else if (wdog_q != '0) begin
      wdog_d = wdog_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= CNT_LOAD;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign wdog_trip       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // favour_rd_q: the reader wins the next tie (the writer was served last).
  always_comb begin
    state_d     = state_q;
    favour_rd_d = favour_rd_q;
    case (state_q)
      IDLE: begin
        if (bus.req_wr && (!bus.req_rd || !favour_rd_q)) begin
          state_d     = OWN_WR;
          favour_rd_d = 1'b1;
        end else if (bus.req_rd) begin
          state_d     = OWN_RD;
          favour_rd_d = 1'b0;
        end
      end
      OWN_WR: begin
        if (!wr_beat || bus.wr_last || wdog_trip) begin
          state_d = IDLE;
        end
        if (wdog_trip) begin
          favour_rd_d = 1'b1;
        end
      end
      OWN_RD: begin
        if (!rd_beat || bus.rd_last || wdog_trip) begin
          state_d = IDLE;
        end
        if (wdog_trip) begin
          favour_rd_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BRAM output is registered inside the BRAM, so it is forwarded in the cycle after the beat.
  always_comb begin
    rd_valid_d = rd_beat;
    rd_hold_d  = rd_valid_q ? bus.douta : rd_hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      favour_rd_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      favour_rd_q <= favour_rd_d;
      rd_valid_q  <= rd_valid_d;
      rd_hold_q   <= rd_hold_d;
    end
  end

  assign bus.gnt_wr   = (state_q == OWN_WR);
  assign bus.gnt_rd   = (state_q == OWN_RD);
  assign bus.ena      = wr_beat || rd_beat;
  assign bus.wea      = wr_beat;
  assign bus.addra    = wr_beat ? bus.wr_addr :
                        rd_beat ? bus.rd_addr : {ADDR_WIDTH{1'b0}};
  assign bus.dina     = wr_beat ? bus.wr_data : {DATA_WIDTH{1'b0}};
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? bus.douta : rd_hold_q;

endmodule

// File: tb/tb_givens_bram_arbiter.sv
// Directed bench for givens_bram_arbiter with a small BRAM model and a read-data scoreboard.
// Follows GIVENS_ARB_WATCHDOG_EN to pick the expected watchdog behaviour.
module tb_givens_bram_arbiter;
  localparam int AW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  givens_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  givens_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WDOG_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (bus.ena) begin
      if (bus.wea) mem[bus.addra] <= bus.dina;
      bus.douta <= mem[bus.addra];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_bus(input string tag, input logic gw, input logic gr, input logic en,
                         input logic we, input logic [1:0] ad, input logic [31:0] di,
                         input logic te);
    chk({tag, ".gnt_wr"}, 32'(bus.gnt_wr), 32'(gw));
    chk({tag, ".gnt_rd"}, 32'(bus.gnt_rd), 32'(gr));
    chk({tag, ".ena"}, 32'(bus.ena), 32'(en));
    chk({tag, ".wea"}, 32'(bus.wea), 32'(we));
    chk({tag, ".addra"}, 32'(bus.addra), 32'(ad));
    chk({tag, ".dina"}, bus.dina, di);
    chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(te));
  endtask

  task automatic expect_bus(input string tag, input logic gw, input logic gr, input logic en,
                            input logic we, input logic [1:0] ad, input logic [31:0] di,
                            input logic te);
    @(negedge clk);
    cmp_bus(tag, gw, gr, en, we, ad, di, te);
  endtask

  task automatic expect_idle(input string tag);
    expect_bus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic push_rd(input logic [31:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every rd_valid must match the oldest expected read, in the predicted cycle.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_valid_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", bus.rd_data, e.data);
        chk("rd_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] wdat [4];
    wdat[0] = 32'h11111111;
    wdat[1] = 32'h22222222;
    wdat[2] = 32'h33333333;
    wdat[3] = 32'h44444444;

    bus.req_wr  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    bus.req_rd  = 1'b0;
    bus.rd_addr = '0;
    bus.rd_last = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_bus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("reset.rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset.rd_data", bus.rd_data, 32'h0);
    step();
    rst = 1'b0;

    // Writer burst of four rows
    bus.req_wr  = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = wdat[0];
    expect_idle("w_req");
    for (int i = 0; i < 4; i++) begin
      step();
      bus.wr_addr = 2'(i);
      bus.wr_data = wdat[i];
      bus.wr_last = (i == 3);
      expect_bus("w_beat", 1'b1, 1'b0, 1'b1, 1'b1, 2'(i), wdat[i], 1'b0);
    end
    step();
    bus.req_wr  = 1'b0;
    bus.wr_last = 1'b0;
    expect_idle("w_done");

    // last without a request does nothing
    step();
    bus.rd_last = 1'b1;
    expect_idle("last_no_req");

    // Reader burst of four rows
    step();
    bus.rd_last = 1'b0;
    bus.req_rd  = 1'b1;
    bus.rd_addr = 2'd0;
    expect_idle("r_req");
    for (int i = 0; i < 4; i++) begin
      step();
      bus.rd_addr = 2'(i);
      bus.rd_last = (i == 3);
      expect_bus("r_beat", 1'b0, 1'b1, 1'b1, 1'b0, 2'(i), 32'h0, 1'b0);
      push_rd(wdat[i]);
    end
    step();
    bus.req_rd  = 1'b0;
    bus.rd_last = 1'b0;
    expect_idle("r_done");
    step();

    // Simultaneous requests after reset: writer first, reader after one IDLE cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_wr  = 1'b1;
    bus.wr_addr = 2'd2;
    bus.wr_data = 32'hA5A5A5A5;
    bus.wr_last = 1'b1;
    bus.req_rd  = 1'b1;
    bus.rd_addr = 2'd2;
    bus.rd_last = 1'b1;
    expect_idle("sim_req");
    step();
    expect_bus("sim_wr", 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'hA5A5A5A5, 1'b0);
    step();
    bus.req_wr  = 1'b0;
    bus.wr_last = 1'b0;
    expect_idle("sim_gap");
    step();
    expect_bus("sim_rd", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0, 1'b0);
    push_rd(32'hA5A5A5A5);
    step();
    bus.req_rd  = 1'b0;
    bus.rd_last = 1'b0;
    expect_idle("sim_rd_done");
    step();
    bus.req_wr  = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 32'h5A5A5A5A;
    bus.wr_last = 1'b1;
    bus.req_rd  = 1'b1;
    bus.rd_addr = 2'd3;
    bus.rd_last = 1'b1;
    expect_idle("sim2_req");
    step();
    expect_bus("sim2_wr", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 32'h5A5A5A5A, 1'b0);
    step();
    bus.req_wr  = 1'b0;
    bus.wr_last = 1'b0;
    bus.req_rd  = 1'b0;
    bus.rd_last = 1'b0;
    expect_idle("sim2_done");

    // Reset during the second read beat
    step();
    bus.req_rd  = 1'b1;
    bus.rd_addr = 2'd0;
    expect_idle("rst_req");
    step();
    expect_bus("rst_b0", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    push_rd(32'h11111111);
    step();
    bus.rd_addr = 2'd1;
    expect_bus("rst_b1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    cmp_bus("rst_now", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("rst_now.rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_now.rd_data", bus.rd_data, 32'h0);
    bus.req_rd = 1'b0;
    step();
    @(negedge clk);
    chk("rst_no_valid", 32'(bus.rd_valid), 32'h0);
    step();
    rst = 1'b0;
    expect_idle("rst_release");

    // Reader aborts after two beats while the writer waits
    step();
    bus.req_rd  = 1'b1;
    bus.rd_addr = 2'd0;
    expect_idle("ab_req");
    step();
    bus.req_wr  = 1'b1;
    bus.wr_addr = 2'd1;
    bus.wr_data = 32'h77777777;
    bus.wr_last = 1'b1;
    expect_bus("ab_b0", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    push_rd(32'h11111111);
    step();
    bus.rd_addr = 2'd1;
    expect_bus("ab_b1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 1'b0);
    push_rd(32'h22222222);
    step();
    bus.req_rd = 1'b0;
    expect_bus("ab_drop", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    step();
    expect_idle("ab_idle");
    step();
    expect_bus("ab_wr", 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h77777777, 1'b0);
    step();
    bus.req_wr  = 1'b0;
    bus.wr_last = 1'b0;
    expect_idle("ab_done");

    // Reader holds the port without last while the writer waits
    step();
    bus.req_rd  = 1'b1;
    bus.rd_addr = 2'd3;
    expect_idle("wd_req");
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) begin
        bus.req_wr  = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'h11111111;
        bus.wr_last = 1'b1;
      end
`ifdef GIVENS_ARB_WATCHDOG_EN
      if (i < 16) begin
        expect_bus("wd_hold", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 1'b0);
        push_rd(32'h5A5A5A5A);
      end else if (i == 16) begin
        expect_bus("wd_revoke", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      end else if (i == 17) begin
        expect_bus("wd_wr", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h11111111, 1'b0);
      end else if (i == 18) begin
        expect_idle("wd_gap");
      end else begin
        expect_bus("wd_rd_again", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 1'b0);
        push_rd(32'h5A5A5A5A);
      end
`else
      expect_bus("nw_hold", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 1'b0);
      push_rd(32'h5A5A5A5A);
`endif
    end
    step();
    bus.req_rd  = 1'b0;
    bus.req_wr  = 1'b0;
    bus.wr_last = 1'b0;
    expect_bus("wd_end", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    step();
    expect_idle("wd_idle");
    repeat (3) step();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
